// File: rtl/seg7_scan_driver_pkg.sv
// Shared display codes and segment patterns for the 4-digit scan driver.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] MINUS_CODE = 4'hE;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_LIT   = 1'b1
  } scan_state_e;

  // True for a nibble that lets a zero to its right be blanked: zero or any blank code.
  function automatic logic is_zero_or_blank(input logic [3:0] code);
    return (code == 4'd0) || ((code >= 4'hA) && (code != MINUS_CODE));
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD/display-code to 7-segment decoder (active-high pattern).
module seg7_scan_driver_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Code to segment lookup; A-D and F fall through to blank.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:       pattern = SEG_0;
      4'd1:       pattern = SEG_1;
      4'd2:       pattern = SEG_2;
      4'd3:       pattern = SEG_3;
      4'd4:       pattern = SEG_4;
      4'd5:       pattern = SEG_5;
      4'd6:       pattern = SEG_6;
      4'd7:       pattern = SEG_7;
      4'd8:       pattern = SEG_8;
      4'd9:       pattern = SEG_9;
      MINUS_CODE: pattern = SEG_MINUS;
      default:    pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver with guard cycles,
// frame-synchronous input capture and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int LZ_BLANK    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit4,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  // XOR masks: the inactive level of each output, also used to flip polarity.
  localparam logic [3:0]    AN_OFF    = (AN_ACT_LOW != 0) ? 4'b1111 : 4'b0000;
  localparam logic [6:0]    SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'b1111111 : 7'b0000000;

  logic [CW-1:0] count_r;
  logic [1:0]    idx_r;
  scan_state_e   state_r;
  logic [3:0]    shadow_r [4];
  logic          load_pend_r;

  logic          slot_end_s;
  logic [CW-1:0] count_nxt_s;
  logic [3:0]    lz_mask_s;
  logic [3:0]    code_s;
  logic [6:0]    pattern_s;
  logic [3:0]    an_onehot_s;

  assign slot_end_s  = (count_r == CNT_LAST);
  assign count_nxt_s = slot_end_s ? CW'(0) : (count_r + CW'(1));
  assign an_onehot_s = 4'b0001 << idx_r;

  // Leading-zero mask from the captured frame; digit1 is never blanked.
  always_comb begin
    lz_mask_s = 4'b0000;
    if (LZ_BLANK != 0) begin
      lz_mask_s[3] = (shadow_r[3] == 4'd0);
      lz_mask_s[2] = (shadow_r[2] == 4'd0) && is_zero_or_blank(shadow_r[3]);
      lz_mask_s[1] = (shadow_r[1] == 4'd0) && is_zero_or_blank(shadow_r[3])
                     && is_zero_or_blank(shadow_r[2]);
    end else begin
      lz_mask_s = 4'b0000;
    end
  end

  // Nibble for the current slot, forced to blank when masked.
  always_comb begin
    code_s = shadow_r[idx_r];
    if (lz_mask_s[idx_r]) begin
      code_s = BLANK_CODE;
    end else begin
      code_s = shadow_r[idx_r];
    end
  end

  seg7_scan_driver_decode u_decode (
    .code    (code_s),
    .pattern (pattern_s)
  );

  // Prescaler, slot index, GUARD/LIT state, shadow capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= CW'(0);
      idx_r       <= 2'd0;
      state_r     <= (GUARD > 0) ? ST_GUARD : ST_LIT;
      load_pend_r <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        shadow_r[i] <= BLANK_CODE;
      end
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_done  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (slot_end_s) begin
        idx_r <= idx_r + 2'd1;
      end
      state_r <= (count_nxt_s >= CNT_GUARD) ? ST_LIT : ST_GUARD;

      // Capture only at frame boundaries so a frame is never torn.
      load_pend_r <= 1'b0;
      if (load_pend_r || (slot_end_s && (idx_r == 2'd3))) begin
        shadow_r[0] <= digit1;
        shadow_r[1] <= digit2;
        shadow_r[2] <= digit3;
        shadow_r[3] <= digit4;
      end

      frame_done <= slot_end_s && (idx_r == 2'd3);

      case (state_r)
        ST_LIT: begin
          an  <= an_onehot_s ^ AN_OFF;
          seg <= pattern_s ^ SEG_OFF;
        end
        ST_GUARD: begin
          an  <= AN_OFF;
          seg <= SEG_OFF;
        end
        default: begin
          an  <= AN_OFF;
          seg <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: three driver configurations share stimulus and are compared
// every cycle against a time-based model, plus hand-computed spot checks.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       rst;
  logic [3:0] digit4, digit3, digit2, digit1;
  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       fd_a, fd_b, fd_c;

  int checks = 0;
  int errors = 0;

  // a: active-low, no blanking; b: active-low with blanking; c: active-high.
  seg7_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GRD), .AN_ACT_LOW(1), .SEG_ACT_LOW(1), .LZ_BLANK(0)) dut_a (
    .clk(clk), .rst(rst), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .an(an_a), .seg(seg_a), .frame_done(fd_a));
  seg7_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GRD), .AN_ACT_LOW(1), .SEG_ACT_LOW(1), .LZ_BLANK(1)) dut_b (
    .clk(clk), .rst(rst), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .an(an_b), .seg(seg_b), .frame_done(fd_b));
  seg7_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GRD), .AN_ACT_LOW(0), .SEG_ACT_LOW(0), .LZ_BLANK(0)) dut_c (
    .clk(clk), .rst(rst), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .an(an_c), .seg(seg_c), .frame_done(fd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_table(input logic [3:0] code);
    case (code)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      4'hE: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [11:0] reset_out(input bit al, input bit sl);
    return {(al ? 4'b1111 : 4'b0000), (sl ? 7'b1111111 : 7'b0000000), 1'b0};
  endfunction

  // Outputs seen after the edge that leaves state k (k cycles since release); sh = {d4,d3,d2,d1}.
  function automatic logic [11:0] model_out(input int k, input logic [15:0] sh,
                                            input bit lz, input bit al, input bit sl);
    int         slot;
    int         cnt;
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic [3:0] code;
    logic [3:0] left;
    bit         blank;
    slot  = (k / DIV) % 4;
    cnt   = k % DIV;
    an_h  = 4'b0000;
    seg_h = 7'b0000000;
    if (cnt >= GRD) begin
      an_h[slot] = 1'b1;
      code = sh[slot*4 +: 4];
      if (lz && slot > 0 && code == 4'd0) begin
        blank = 1'b1;
        for (int j = slot + 1; j < 4; j++) begin
          left = sh[j*4 +: 4];
          if (!(left == 4'd0 || (left >= 4'hA && left != 4'hE))) blank = 1'b0;
        end
        if (blank) code = 4'hF;
      end
      seg_h = seg_table(code);
    end
    if (al) an_h = ~an_h;
    if (sl) seg_h = ~seg_h;
    return {an_h, seg_h, ((k % FRAME) == FRAME - 1)};
  endfunction

  int          t_m;
  logic [15:0] sh_m;
  logic [11:0] exp_a, exp_b, exp_c;

  // Model: elapsed cycles since release plus the frame value captured at frame starts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_m   <= 0;
      sh_m  <= 16'hFFFF;
      exp_a <= reset_out(1'b1, 1'b1);
      exp_b <= reset_out(1'b1, 1'b1);
      exp_c <= reset_out(1'b0, 1'b0);
    end else begin
      t_m   <= t_m + 1;
      exp_a <= model_out(t_m, sh_m, 1'b0, 1'b1, 1'b1);
      exp_b <= model_out(t_m, sh_m, 1'b1, 1'b1, 1'b1);
      exp_c <= model_out(t_m, sh_m, 1'b0, 1'b0, 1'b0);
      if (t_m == 0 || ((t_m + 1) % FRAME) == 0) sh_m <= {digit4, digit3, digit2, digit1};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0d)", name, act, expv, t_m);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    chk("model_a", {20'd0, an_a, seg_a, fd_a}, {20'd0, exp_a});
    chk("model_b", {20'd0, an_b, seg_b, fd_b}, {20'd0, exp_b});
    chk("model_c", {20'd0, an_c, seg_c, fd_c}, {20'd0, exp_c});
  end

  task automatic go_to(input int n);
    int g;
    g = 0;
    while (t_m < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (t_m != n) begin
      checks++;
      errors++;
      $display("FAIL go_to: reached cycle %0d expected %0d", t_m, n);
    end
  endtask

  task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3,
                            input logic [3:0] d2, input logic [3:0] d1);
    #2;
    digit4 = d4; digit3 = d3; digit2 = d2; digit1 = d1;
  endtask

  initial begin
    rst = 1'b0;
    digit4 = 4'd0; digit3 = 4'hF; digit2 = 4'hF; digit1 = 4'hF;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_an_a", {28'd0, an_a}, 32'b1111);
    chk("reset_seg_c", {25'd0, seg_c}, 32'b0000000);
    #2 rst = 1'b0;

    // Blank/zero frame straight after reset
    go_to(1);  chk("s1_c1_an", {28'd0, an_a}, 32'b1111);
    go_to(2);  chk("s1_c2_an", {28'd0, an_a}, 32'b1111);
    go_to(3);  chk("s1_c3_an", {28'd0, an_a}, 32'b1110);
               chk("s1_c3_seg", {25'd0, seg_a}, 32'b1111111);
               chk("s1_c3_an_c", {28'd0, an_c}, 32'b0001);
    go_to(27); chk("s1_slot3_an", {28'd0, an_a}, 32'b0111);
               chk("s1_slot3_seg", {25'd0, seg_a}, 32'b1000000);
               chk("s1_slot3_lz", {25'd0, seg_b}, 32'b1111111);
    go_to(31); chk("s1_fd_pre", {31'd0, fd_a}, 32'd0);
    go_to(32); chk("s1_fd", {31'd0, fd_a}, 32'd1);
    go_to(33); chk("s1_fd_post", {31'd0, fd_a}, 32'd0);

    // All nines, both polarities
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    go_to(67); chk("s2_an0", {28'd0, an_a}, 32'b1110);
               chk("s2_seg", {25'd0, seg_a}, 32'b0010000);
               chk("s7_an0", {28'd0, an_c}, 32'b0001);
               chk("s7_seg", {25'd0, seg_c}, 32'b1101111);
    go_to(75); chk("s2_an1", {28'd0, an_a}, 32'b1101);

    // No tearing: digit1 change in slot 1 waits for next frame
    set_digits(4'd1, 4'd2, 4'd3, 4'd5);
    go_to(99);  chk("s3_five", {25'd0, seg_a}, 32'b0010010);
    go_to(106); set_digits(4'd1, 4'd2, 4'd3, 4'd7);
    go_to(107); chk("s3_slot1_an", {28'd0, an_a}, 32'b1101);
                chk("s3_slot1_seg", {25'd0, seg_a}, 32'b0110000);
    go_to(123); chk("s3_slot3_seg", {25'd0, seg_a}, 32'b1111001);
    go_to(131); chk("s3_seven", {25'd0, seg_a}, 32'b1111000);

    // Minus sign
    go_to(140); set_digits(4'hE, 4'd1, 4'd2, 4'd3);
    go_to(187); chk("s5_an", {28'd0, an_a}, 32'b0111);
                chk("s5_minus", {25'd0, seg_a}, 32'b0111111);
                chk("s5_minus_lz", {25'd0, seg_b}, 32'b0111111);

    // Leading-zero blanking
    go_to(190); set_digits(4'd0, 4'd0, 4'd4, 4'd2);
    go_to(195); chk("s4_slot0", {25'd0, seg_b}, 32'b0100100);
    go_to(203); chk("s4_slot1", {25'd0, seg_b}, 32'b0011001);
    go_to(211); chk("s4_slot2", {25'd0, seg_b}, 32'b1111111);
                chk("s4_slot2_an", {28'd0, an_b}, 32'b1011);
    go_to(219); chk("s4_slot3", {25'd0, seg_b}, 32'b1111111);
                chk("s4_slot3_nolz", {25'd0, seg_a}, 32'b1000000);
    go_to(220); set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    go_to(227); chk("s4_zero_slot0", {25'd0, seg_b}, 32'b1000000);
    go_to(235); chk("s4_zero_slot1", {25'd0, seg_b}, 32'b1111111);
                chk("s4_zero_nolz", {25'd0, seg_a}, 32'b1000000);

    // Asynchronous reset mid-LIT in slot 2
    go_to(245); chk("s6_pre_an", {28'd0, an_a}, 32'b1011);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_an", {28'd0, an_a}, 32'b1111);
    chk("s6_async_seg", {25'd0, seg_a}, 32'b1111111);
    chk("s6_async_an_c", {28'd0, an_c}, 32'b0000);
    chk("s6_async_seg_c", {25'd0, seg_c}, 32'b0000000);
    @(negedge clk);
    #2 rst = 1'b0;
    go_to(1); chk("s6_c1_an", {28'd0, an_a}, 32'b1111);
    go_to(3); chk("s6_c3_an", {28'd0, an_a}, 32'b1110);
              chk("s6_c3_seg", {25'd0, seg_a}, 32'b1000000);

    // Randomized inputs with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 8) begin
        set_digits(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
